// File: rtl/exec_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// exec_sequencer_pkg
//   Shared definitions for the multi-cycle execution sequencer and the
//   instruction decoder: sequencer state encoding, halt-reason codes and the
//   memory-operation encoding the decoder drives on dec_memOp.
// -----------------------------------------------------------------------------
package exec_sequencer_pkg;

    localparam int XLEN = 64;   // address / pc / counter width
    localparam int ILEN = 32;   // instruction word width

    // Sequencer states; exactly one is active in any cycle.
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        WAIT_I = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WAIT_D = 3'd5,
        WB     = 3'd6,
        HALT   = 3'd7
    } state_t;

    // Reason the core stopped, reported on halt_code.
    typedef enum logic [1:0] {
        HALT_NONE     = 2'b00,
        HALT_EBREAK   = 2'b01,
        HALT_MISALIGN = 2'b10
    } halt_code_t;

    // Memory operation class produced by the decoder.
    typedef enum logic [1:0] {
        MEM_NO = 2'b00,
        MEM_L  = 2'b01,
        MEM_LU = 2'b10,
        MEM_S  = 2'b11
    } mem_op_t;

    // Loads (signed or unsigned) wait for read data; stores do not.
    function automatic logic is_load(input logic [1:0] op);
        return (op == MEM_L) || (op == MEM_LU);
    endfunction

endpackage

// File: rtl/exec_sequencer_pc_reg.sv
// -----------------------------------------------------------------------------
// exec_sequencer_pc_reg
//   Program counter with redirect and alignment checking.
//
//   Ports
//     clk, rst_n  core clock, asynchronous active-low reset
//     update      write-back cycle: advance or redirect the pc
//     redirect    jump or taken branch
//     target      redirect target from the ALU (bit 0 is ignored)
//     pc          current instruction address
//     fault       redirect target is not 4-byte aligned after bit-0 clear;
//                 the pc is left untouched when this is set
// -----------------------------------------------------------------------------
module exec_sequencer_pc_reg
    import exec_sequencer_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            update,
    input  logic            redirect,
    input  logic [XLEN-1:0] target,
    output logic [XLEN-1:0] pc,
    output logic            fault
);

    logic [XLEN-1:0] target_clr;
    logic [XLEN-1:0] pc_next;

    // Jump targets have bit 0 cleared (JALR semantics); anything left in
    // bit 1 means the target cannot hold a 32-bit instruction.
    assign target_clr = target & ~{{(XLEN-1){1'b0}}, 1'b1};
    assign fault      = redirect && target_clr[1];
    assign pc_next    = redirect ? target_clr : pc + {{(XLEN-3){1'b0}}, 3'd4};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the clock edge, independent of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (update && !fault) begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/exec_sequencer.sv
// -----------------------------------------------------------------------------
// exec_sequencer
//   Multi-cycle control sequencer for a simple RV64 core. Walks each
//   instruction through FETCH -> WAIT_I -> DECODE -> EXEC -> [MEM -> [WAIT_D]]
//   -> WB, halting on EBREAK or on a misaligned jump/branch target.
//
//   Ports
//     clk, rst_n                         core clock, async active-low reset
//     imem_req_valid/ready, imem_req_addr  instruction fetch request
//     imem_rsp_valid, imem_rsp_data      instruction fetch response
//     ir, pc                             instruction register / its address
//     dec_regWEN, dec_memOp, dec_jmp     decoder controls for ir
//     br_taken, next_target              branch outcome and target from ALU
//     dmem_req_valid/ready, dmem_rsp_valid data-memory handshake
//     rf_wen                             register-file write strobe
//     halt, halt_code                    core stopped and why
//     instret                            retired-instruction counter
// -----------------------------------------------------------------------------
module exec_sequencer
    import exec_sequencer_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC    = 64'h8000_0000,
    parameter logic [ILEN-1:0] EBREAK_INSN = 32'h0010_0073
) (
    input  logic            clk,
    input  logic            rst_n,
    // instruction memory
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    // decoder / datapath
    output logic [ILEN-1:0] ir,
    output logic [XLEN-1:0] pc,
    input  logic            dec_regWEN,
    input  logic [1:0]      dec_memOp,
    input  logic            dec_jmp,
    input  logic            br_taken,
    input  logic [XLEN-1:0] next_target,
    // data memory
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    input  logic            dmem_rsp_valid,
    // status
    output logic            rf_wen,
    output logic            halt,
    output logic [1:0]      halt_code,
    output logic [XLEN-1:0] instret
);

    state_t state;
    state_t state_next;

    logic   redirect;
    logic   pc_fault;
    logic   is_ebreak;
    logic   in_wb;

    assign redirect      = dec_jmp || br_taken;
    assign is_ebreak     = (ir == EBREAK_INSN);
    assign in_wb         = (state == WB);
    assign imem_req_addr = pc;

    exec_sequencer_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .update   (in_wb),
        .redirect (redirect),
        .target   (next_target),
        .pc       (pc),
        .fault    (pc_fault)
    );

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic. Responses arriving outside WAIT_I / WAIT_D are simply
    // never looked at, which is what makes stray responses harmless.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: defaulting every always_comb output first means no path can
        // leave it unassigned, so no latch is inferred.
        state_next = state;
        unique case (state)
            FETCH:  if (imem_req_ready) state_next = WAIT_I;
            WAIT_I: if (imem_rsp_valid) state_next = DECODE;
            DECODE: state_next = is_ebreak ? HALT : EXEC;
            EXEC:   state_next = (mem_op_t'(dec_memOp) != MEM_NO) ? MEM : WB;
            MEM: begin
                if (dmem_req_ready) begin
                    state_next = is_load(dec_memOp) ? WAIT_D : WB;
                end
            end
            WAIT_D: if (dmem_rsp_valid) state_next = WB;
            WB:     state_next = pc_fault ? HALT : FETCH;
            HALT:   state_next = HALT;
            default: state_next = FETCH;
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs: pure decodes of the registered state, so they cannot glitch
    // on state transitions. rf_wen is suppressed when write-back faults.
    // -------------------------------------------------------------------------
    always_comb begin
        imem_req_valid = 1'b0;
        dmem_req_valid = 1'b0;
        rf_wen         = 1'b0;
        halt           = 1'b0;
        unique case (state)
            FETCH:   imem_req_valid = 1'b1;
            MEM:     dmem_req_valid = 1'b1;
            WB:      rf_wen         = dec_regWEN && !pc_fault;
            HALT:    halt           = 1'b1;
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Instruction register, retire counter and halt reason
    // -------------------------------------------------------------------------
    // NOTE: ir is a single control register, not a storage array, so it is
    // reset like any other flop; a cleared ir can never decode as EBREAK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir        <= '0;
            instret   <= '0;
            halt_code <= HALT_NONE;
        end else begin
            if (state == WAIT_I && imem_rsp_valid) begin
                ir <= imem_rsp_data;
            end
            if (in_wb && !pc_fault) begin
                instret <= instret + {{(XLEN-1){1'b0}}, 1'b1};
            end
            if (state == DECODE && is_ebreak) begin
                halt_code <= HALT_EBREAK;
            end else if (in_wb && pc_fault) begin
                halt_code <= HALT_MISALIGN;
            end
        end
    end

endmodule

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h8000_0000, meaning first fetch address after reset.
REQ-002 SHALL have parameter EBREAK_INSN, default 32'h0010_0073, meaning the instruction word that halts the core.
REQ-003 clk  in  1  core clock, rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 imem_req_valid  out  1  fetch request; imem_req_addr  out  64  fetch address (= pc).
REQ-006 imem_req_ready  in  1  fetch request accepted; imem_rsp_valid  in  1  fetch data valid; imem_rsp_data  in  32  instruction word.
REQ-007 ir  out  32  instruction register, drives the decoder; pc  out  64  current instruction address.
REQ-008 dec_regWEN  in  1, dec_memOp  in  2, dec_jmp  in  1  decoder controls for ir.
REQ-009 br_taken  in  1  branch condition from ALU; next_target  in  64  jump/branch target from ALU.
REQ-010 dmem_req_valid  out  1; dmem_req_ready  in  1; dmem_rsp_valid  in  1  data-memory handshake.
REQ-011 rf_wen  out  1  register-file write strobe; halt  out  1  core stopped; halt_code  out  2  00 none, 01 ebreak, 10 misaligned target; instret  out  64  retired-instruction count.

Function
REQ-012 SHALL implement states FETCH, WAIT_I, DECODE, EXEC, MEM, WAIT_D, WB, HALT; exactly one active per cycle.
REQ-013 FETCH: imem_req_valid=1; on imem_req_ready go WAIT_I, else stay with pc/addr held stable.
REQ-014 WAIT_I: on imem_rsp_valid load ir<=imem_rsp_data and go DECODE; else stay.
REQ-015 DECODE: if ir==EBREAK_INSN go HALT with halt_code=01; else go EXEC.
REQ-016 EXEC: one cycle; if dec_memOp!=MEM_NO go MEM, else go WB.
REQ-017 MEM: dmem_req_valid=1; on dmem_req_ready go WAIT_D for load (MEM_L/MEM_LU); go WB directly for store (MEM_S).
REQ-018 WAIT_D: on dmem_rsp_valid go WB; else stay.
REQ-019 WB: single cycle; rf_wen=dec_regWEN; instret+=1 (wraps modulo 2^64); go FETCH.
REQ-020 WB pc update: if dec_jmp or br_taken, pc<=next_target with bit0 cleared; else pc<=pc+4 (modulo 2^64).
REQ-021 If redirect target bits[1]!=0 after bit0 clear, SHALL not update pc, not assert rf_wen, not increment instret, go HALT with halt_code=10.
REQ-022 HALT: absorbing; all request outputs and rf_wen low; halt=1; leaves only via reset.
REQ-023 Latency: ALU op with ready/rsp each arriving one cycle after request = 5 cycles FETCH-to-FETCH; load +2, store +1.
REQ-024 imem_rsp_valid outside WAIT_I and dmem_rsp_valid outside WAIT_D SHALL be ignored.
REQ-025 rf_wen, imem_req_valid, dmem_req_valid SHALL be registered-state decodes, glitch-free, high only in their stated states.

Reset
REQ-026 rst_n low SHALL asynchronously force state=FETCH, pc=RESET_PC, ir=0, instret=0, halt=0, halt_code=00, all valids and rf_wen=0.
REQ-027 Reset asserted mid-transaction SHALL abandon it; first post-reset cycle issues fetch at RESET_PC.

Structure
REQ-028 State encoding, halt_code values and MEM_NO/MEM_L/MEM_LU/MEM_S encodings SHALL live in the shared defines file, identical to those the decoder uses.
REQ-029 Sub-module pc_reg (pc + redirect/alignment logic) is natural; all else in one module.

Verification
REQ-030 Reset, ready/rsp one cycle after request, ir=addi x1,x0,5 -> fetch addr 0x8000_0000, rf_wen pulse in cycle 5, next fetch 0x8000_0004, instret=1.
REQ-031 Load with dmem_rsp_valid delayed 3 cycles -> stays WAIT_D 3 cycles, single rf_wen pulse, instret=1.
REQ-032 Branch br_taken=1, next_target=0x8000_0100 -> next fetch 0x8000_0100, rf_wen=0; target 0x8000_0102 -> halt=1, halt_code=10, pc unchanged.
REQ-033 ir=0x0010_0073 -> halt=1, halt_code=01 in cycle after DECODE, no further requests for 20 cycles.
REQ-034 rst_n pulsed low during WAIT_D with spurious dmem_rsp_valid after release -> fetch at 0x8000_0000, response ignored, instret=0.
REQ-035 imem_req_ready held low 10 cycles -> imem_req_valid and addr stable throughout, no state advance.
